// File: rtl/signed_frame_extrema.sv
// Frame-wise signed max/min/count accumulator with a valid/ready input stream and a held result.
// A frame closes on in_last or when FRAME_LEN samples have been accepted. The result then stays on the outputs until it is consumed.
module signed_frame_extrema #(
  parameter int FRAME_LEN = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_data,
  input  logic       in_last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_max,
  output logic [3:0] out_min,
  output logic [3:0] out_cnt,
  output logic       dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
  // Valid never depends on ready. Ready is a function of state alone.
  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_e;

  localparam logic [3:0] FRAME_LEN_C = 4'(FRAME_LEN);

  state_e             state_q, state_d;
  logic        [3:0] cnt_q, cnt_d;
  logic signed [3:0] max_q, max_d;
  logic signed [3:0] min_q, min_d;

  logic              in_fire;
  logic              out_fire;
  logic              frame_close;
  logic        [3:0] cnt_inc;
  logic signed [3:0] sample;

  assign sample      = $signed(in_data);
  assign in_fire     = in_valid & in_ready;
  assign out_fire    = out_valid & out_ready;
  assign cnt_inc     = cnt_q + 4'd1;
  assign frame_close = in_last | (cnt_inc == FRAME_LEN_C);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ACC;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ACC:     if (in_fire && frame_close) state_d = HOLD;
      HOLD:    if (out_fire) state_d = ACC;
      default: state_d = ACC;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == ACC);
    out_valid = (state_q == HOLD);
    dbg_state = state_q;
  end

  // The first sample of a frame seeds both extremes. Later samples replace an extreme only when strictly beyond it.
  always_comb begin
    cnt_d = cnt_q;
    max_d = max_q;
    min_d = min_q;
    if (in_fire) begin
      cnt_d = cnt_inc;
      if (cnt_q == 4'd0) begin
        max_d = sample;
        min_d = sample;
      end else begin
        if (sample > max_q) max_d = sample;
        if (sample < min_q) min_d = sample;
      end
    end else if (out_fire) begin
      cnt_d = 4'd0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= 4'd0;
      max_q <= 4'sd0;
      min_q <= 4'sd0;
    end else begin
      cnt_q <= cnt_d;
      max_q <= max_d;
      min_q <= min_d;
    end
  end

  assign out_max = max_q;
  assign out_min = min_q;
  assign out_cnt = cnt_q;

endmodule

// File: tb/tb_signed_frame_extrema.sv
// Bench for signed_frame_extrema. It drives directed frames and a random tail against a frame-level reference model.
// Inputs change 1ns after the rising edge. The DUT is observed on the falling edge.
module tb_signed_frame_extrema;

  localparam int FRAME_LEN = 8;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_max;
  logic [3:0] out_min;
  logic [3:0] out_cnt;
  logic       dbg_state;

  signed_frame_extrema #(.FRAME_LEN(FRAME_LEN)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_max   (out_max),
    .out_min   (out_min),
    .out_cnt   (out_cnt),
    .dbg_state (dbg_state)
  );

  // Clock and reset block.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int  checks = 0;
  int  errors = 0;
  bit  run_chk = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model. It keeps the samples of the open frame and the expected results that are waiting for output.
  logic signed [3:0] frame_q[$];
  logic [11:0]       exp_q[$];
  bit                m_hold = 1'b0;

  always @(negedge clk) begin
    if (run_chk) begin
      if (!reset) begin
        frame_q.delete();
        exp_q.delete();
        m_hold = 1'b0;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_cnt", 32'(out_cnt), 32'd0);
        chk("rst_out_max", 32'(out_max), 32'd0);
        chk("rst_out_min", 32'(out_min), 32'd0);
      end else begin
        chk("in_ready", 32'(in_ready), 32'(!m_hold));
        chk("out_valid", 32'(out_valid), 32'(m_hold));
        chk("dbg_state", 32'(dbg_state), 32'(m_hold));
        if (m_hold) begin
          if (exp_q.size() == 0) chk("exp_q_empty", 32'd1, 32'd0);
          else chk("result", 32'({out_max, out_min, out_cnt}), 32'(exp_q[0]));
        end
        // Work out what the coming rising edge will do.
        if (!m_hold && in_valid) begin
          frame_q.push_back($signed(in_data));
          if (in_last || frame_q.size() == FRAME_LEN) begin
            logic signed [3:0] mx, mn;
            mx = frame_q[0];
            mn = frame_q[0];
            foreach (frame_q[i]) begin
              if (frame_q[i] > mx) mx = frame_q[i];
              if (frame_q[i] < mn) mn = frame_q[i];
            end
            exp_q.push_back({mx, mn, 4'(frame_q.size())});
            frame_q.delete();
            m_hold = 1'b1;
          end
        end else if (m_hold && out_ready) begin
          void'(exp_q.pop_front());
          m_hold = 1'b0;
        end
      end
    end
  end

  // Driver tasks. Each one is entered 1ns after a rising edge and returns at the same phase.
  task automatic send(input logic [3:0] d, input logic l);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 50) begin
        chk("send_timeout", 32'd0, 32'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic expect_res(input string name, input logic [3:0] mx, input logic [3:0] mn,
                            input logic [3:0] cn);
    @(negedge clk);
    chk({name, "_valid"}, 32'(out_valid), 32'd1);
    chk({name, "_max"}, 32'(out_max), 32'(mx));
    chk({name, "_min"}, 32'(out_min), 32'(mn));
    chk({name, "_cnt"}, 32'(out_cnt), 32'(cn));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 4'h0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    run_chk   = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // Full frame of eight samples, closed by the sample count: 3,-2,7,-8,0,1,-1,5.
    send(4'h3, 0); send(4'hE, 0); send(4'h7, 0); send(4'h8, 0);
    send(4'h0, 0); send(4'h1, 0); send(4'hF, 0); send(4'h5, 0);
    expect_res("full8", 4'h7, 4'h8, 4'd8);

    // Signed comparison: 2 then -3.
    send(4'h2, 0); send(4'hD, 1);
    expect_res("signed2", 4'h2, 4'hD, 4'd2);

    // Single sample with in_last.
    send(4'hC, 1);
    expect_res("single", 4'hC, 4'hC, 4'd1);

    // Equal extremes: -8,-8,7,7.
    send(4'h8, 0); send(4'h8, 0); send(4'h7, 0); send(4'h7, 1);
    expect_res("equal", 4'h7, 4'h8, 4'd4);

    // in_last together with the sample count reaching FRAME_LEN.
    for (int i = 0; i < FRAME_LEN; i++) send(4'(i - 4), logic'(i == FRAME_LEN - 1));
    expect_res("last_and_full", 4'h3, 4'hC, 4'd8);

    // Backpressure: the result is held while in_valid stays high.
    out_ready = 1'b0;
    send(4'h1, 0); send(4'hB, 1);
    in_valid = 1'b1;
    in_data  = 4'h3;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_hold", 32'({out_max, out_min, out_cnt}), 32'({4'h1, 4'hB, 4'd2}));
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    chk("bp_still_valid", 32'(out_valid), 32'd1);
    @(negedge clk);
    chk("bp_after_xfer_ready", 32'(in_ready), 32'd1);
    chk("bp_after_xfer_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    send(4'hF, 1);
    expect_res("bp_next", 4'h3, 4'hF, 4'd2);

    // Reset in the middle of a frame, then a fresh frame.
    send(4'h1, 0); send(4'h2, 0); send(4'h3, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    for (int i = 0; i < FRAME_LEN; i++) send(4'h6, 0);
    expect_res("after_rst", 4'h6, 4'h6, 4'd8);

    // Random tail checked by the model only.
    for (int c = 0; c < 400; c++) begin
      in_valid  = logic'($urandom_range(0, 1));
      in_data   = 4'($urandom_range(0, 15));
      in_last   = logic'($urandom_range(0, 3) == 0);
      out_ready = logic'($urandom_range(0, 2) != 0);
      reset     = logic'(c != 200);
      @(posedge clk);
      #1;
    end
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    run_chk = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
